// File: rtl/instr_mem_pkg.sv
// Shared constants and state type for the instruction memory loader.
// Image depth is fixed at a power of two so the write pointer wraps by itself.
package instr_mem_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

  function automatic logic count_ok(
    input logic [ADDR_WIDTH:0] c
  );
    return (c != '0) &&
           (c <= (ADDR_WIDTH+1)'(DEPTH));
  endfunction

endpackage

// File: rtl/loader_addr_counter.sv
// Write pointer (modulo DEPTH) and remaining-word down-counter.
// last flags that the next step consumes the final word.
module loader_addr_counter
  import instr_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  last
);

  logic [ADDR_WIDTH:0] rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      rem <= '0;
    end else if (load) begin
      ptr <= base;
      rem <= count;
    end else if (step) begin
      ptr <= ptr + 1'b1;
      rem <= rem - 1'b1;
    end
  end

  assign last = (rem == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/instruction_memory_loader.sv
// Streams instruction words into the 8x32 instruction memory.
// Each accepted word is written exactly one cycle later.
module instruction_memory_loader
  import instr_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [DATA_WIDTH-1:0] checksum
);

  loader_state_t state;
  loader_state_t state_nxt;

  logic [ADDR_WIDTH-1:0] ptr;
  logic                  last;
  logic                  accept;
  logic                  start_ok;
  logic                  start_bad;
  logic                  kill;

  assign start_ok  = (state == IDLE) && start &&
                     count_ok(word_count);
  assign start_bad = (state == IDLE) && start &&
                     !count_ok(word_count);
  assign kill      = (state == LOAD) && abort;
  // abort wins over a same-cycle handshake
  assign accept    = in_ready && in_valid && !abort;

  loader_addr_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (start_ok),
    .step  (accept),
    .base  (base_addr),
    .count (word_count),
    .ptr   (ptr),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (abort)
          state_nxt = IDLE;
        else if (accept && last)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= NOP;
      error         <= 1'b0;
      words_written <= '0;
      checksum      <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr       <= ptr;
        wr_data       <= in_data;
        checksum      <= checksum ^ in_data;
        words_written <= words_written + 1'b1;
      end
      if (start_ok) begin
        checksum      <= '0;
        words_written <= '0;
        error         <= 1'b0;
      end else if (start_bad || kill) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed vector bench for instruction_memory_loader.
// Table covers normal/wrap/illegal sessions; stall, abort, reset by hand.
module tb_instruction_memory_loader;
  import instr_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  base_addr;
  logic [3:0]  word_count;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  words_written;
  logic [31:0] checksum;

  int total;
  int bad;

  instruction_memory_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written),
    .checksum      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  base;
    logic [3:0]  cnt;
    logic        ab;
    logic        iv;
    logic [31:0] d;
    logic        e_we;
    logic [2:0]  e_addr;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic        e_rdy;
    logic [3:0]  e_ww;
    logic [31:0] e_cs;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic st,
                       input logic [2:0] b,
                       input logic [3:0] c,
                       input logic ab,
                       input logic iv,
                       input logic [31:0] d);
    start      = st;
    base_addr  = b;
    word_count = c;
    abort      = ab;
    in_valid   = iv;
    in_data    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".wr_en"}, 32'(wr_en), 0);
    chk({nm, ".wr_addr"}, 32'(wr_addr), 0);
    chk({nm, ".wr_data"}, wr_data, 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".error"}, 32'(error), 0);
    chk({nm, ".in_ready"}, 32'(in_ready), 0);
    chk({nm, ".ww"}, 32'(words_written), 0);
    chk({nm, ".cs"}, checksum, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{1, 0, 3, 0, 0, 32'h0,
                 0, 0, 1, 0, 0, 1, 0, 32'h0};
    vecs[1]  = '{0, 0, 0, 0, 1, 32'h11111111,
                 1, 0, 1, 0, 0, 1, 1, 32'h11111111};
    vecs[2]  = '{0, 0, 0, 0, 1, 32'h22222222,
                 1, 1, 1, 0, 0, 1, 2, 32'h33333333};
    vecs[3]  = '{0, 0, 0, 0, 1, 32'h33333333,
                 1, 2, 1, 1, 0, 0, 3, 32'h0};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h0,
                 0, 0, 0, 0, 0, 0, 3, 32'h0};
    vecs[5]  = '{1, 6, 4, 0, 0, 32'h0,
                 0, 0, 1, 0, 0, 1, 0, 32'h0};
    vecs[6]  = '{0, 0, 0, 0, 1, 32'hA0000001,
                 1, 6, 1, 0, 0, 1, 1, 32'hA0000001};
    vecs[7]  = '{0, 0, 0, 0, 1, 32'h0B000002,
                 1, 7, 1, 0, 0, 1, 2, 32'hAB000003};
    vecs[8]  = '{0, 0, 0, 0, 1, 32'h00C00004,
                 1, 0, 1, 0, 0, 1, 3, 32'hABC00007};
    vecs[9]  = '{0, 0, 0, 0, 1, 32'h000D0008,
                 1, 1, 1, 1, 0, 0, 4, 32'hABCD000F};
    vecs[10] = '{0, 0, 0, 0, 0, 32'h0,
                 0, 0, 0, 0, 0, 0, 4, 32'hABCD000F};
    vecs[11] = '{1, 2, 0, 0, 0, 32'h0,
                 0, 0, 0, 0, 1, 0, 4, 32'hABCD000F};
    vecs[12] = '{0, 0, 0, 0, 1, 32'h55555555,
                 0, 0, 0, 0, 1, 0, 4, 32'hABCD000F};
    vecs[13] = '{1, 3, 9, 0, 0, 32'h0,
                 0, 0, 0, 0, 1, 0, 4, 32'hABCD000F};
    vecs[14] = '{1, 5, 1, 0, 0, 32'h0,
                 0, 0, 1, 0, 0, 1, 0, 32'h0};
    vecs[15] = '{0, 0, 0, 0, 1, 32'hDEADBEEF,
                 1, 5, 1, 1, 0, 0, 1, 32'hDEADBEEF};
    vecs[16] = '{0, 0, 0, 0, 0, 32'h0,
                 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF};

    reset = 1'b0;
    idle();
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].base, vecs[i].cnt,
            vecs[i].ab, vecs[i].iv, vecs[i].d);
      tick();
      chk($sformatf("v%0d.wr_en", i),
          32'(wr_en), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d.wr_addr", i),
            32'(wr_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d.wr_data", i),
            wr_data, vecs[i].d);
      end
      chk($sformatf("v%0d.busy", i),
          32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.done", i),
          32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d.error", i),
          32'(error), 32'(vecs[i].e_err));
      chk($sformatf("v%0d.in_ready", i),
          32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.ww", i),
          32'(words_written), 32'(vecs[i].e_ww));
      chk($sformatf("v%0d.cs", i),
          checksum, vecs[i].e_cs);
    end

    // stall with a stray start mid-session
    drive(1, 2, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h1);
    tick();
    chk("stall.we1", 32'(wr_en), 1);
    chk("stall.addr1", 32'(wr_addr), 2);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("stall.we_gap", 32'(wr_en), 0);
    chk("stall.busy", 32'(busy), 1);
    drive(1, 7, 8, 0, 0, 0);
    tick();
    chk("stall.we_gap2", 32'(wr_en), 0);
    chk("stall.err", 32'(error), 0);
    chk("stall.ww_mid", 32'(words_written), 1);
    drive(0, 0, 0, 0, 1, 32'h2);
    tick();
    chk("stall.we2", 32'(wr_en), 1);
    chk("stall.addr2", 32'(wr_addr), 3);
    chk("stall.done", 32'(done), 1);
    idle();
    tick();
    chk("stall.we_end", 32'(wr_en), 0);
    chk("stall.busy_end", 32'(busy), 0);
    chk("stall.ww", 32'(words_written), 2);
    chk("stall.cs", checksum, 32'h3);

    // abort with the second word
    drive(1, 0, 5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'hAAAA0000);
    tick();
    chk("abort.we1", 32'(wr_en), 1);
    chk("abort.addr1", 32'(wr_addr), 0);
    drive(0, 0, 0, 1, 1, 32'h0000BBBB);
    tick();
    chk("abort.we2", 32'(wr_en), 0);
    chk("abort.err", 32'(error), 1);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.ww", 32'(words_written), 1);
    chk("abort.cs", checksum, 32'hAAAA0000);
    drive(0, 0, 0, 0, 1, 32'h0000CCCC);
    tick();
    chk("abort.we3", 32'(wr_en), 0);
    chk("abort.rdy", 32'(in_ready), 0);
    chk("abort.err2", 32'(error), 1);

    // asynchronous reset mid-session
    drive(1, 1, 4, 0, 0, 0);
    tick();
    chk("rst.err_clr", 32'(error), 0);
    drive(0, 0, 0, 0, 1, 32'h12345678);
    tick();
    drive(0, 0, 0, 0, 1, 32'h9ABCDEF0);
    tick();
    chk("rst.we_pre", 32'(wr_en), 1);
    chk("rst.addr_pre", 32'(wr_addr), 2);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst.async");
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst.post%0d.we", i),
          32'(wr_en), 0);
      chk($sformatf("rst.post%0d.busy", i),
          32'(busy), 0);
    end
    drive(1, 4, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'hCAFEF00D);
    tick();
    chk("rst.new.we", 32'(wr_en), 1);
    chk("rst.new.addr", 32'(wr_addr), 4);
    chk("rst.new.data", wr_data, 32'hCAFEF00D);
    chk("rst.new.done", 32'(done), 1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Write-side counterpart of the 8x32 instruction memory: accepts a stream of 32-bit instruction words over a valid/ready handshake and issues sequential word writes (wr_en/wr_addr/wr_data) into the memory words.
- A programming session is started by a start command carrying a base address and word count.
- Addresses wrap modulo DEPTH.
- Reports busy, done, error, words written and an XOR checksum for the loaded image.

Parameters:
- ADDR_WIDTH, 3, width of the word address.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 8, number of memory words; fixed at 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  begin a session; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address; latched on accepted start.
- word_count  input  ADDR_WIDTH+1  number of words to load, legal range 1..DEPTH.
- abort  input  1  cancel the session in progress.
- in_valid  input  1  in_data holds a word.
- in_data  input  DATA_WIDTH  instruction word.
- in_ready  output  1  loader accepts a word this cycle.
- wr_en  output  1  one-cycle write strobe to memory.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  DATA_WIDTH  write data.
- busy  output  1  session in progress.
- done  output  1  one-cycle pulse at successful completion.
- error  output  1  sticky error flag; cleared by the next accepted start.
- words_written  output  ADDR_WIDTH+1  writes issued in the current/last session.
- checksum  output  DATA_WIDTH  XOR of all words written in the current/last session.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including the wr_addr/wr_data registers.
  - The internal pointer and remaining count are cleared.
  - A reset mid-session abandons it immediately; no further wr_en.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with 1 <= word_count <= DEPTH:
    - latch base_addr into the pointer and word_count into the remaining count;
    - clear checksum, words_written and error;
    - next state LOAD.
  - start=1 with word_count=0 or word_count>DEPTH: set error=1, stay in IDLE, no writes.
- LOAD:
  - busy=1, in_ready=1. in_ready is registered/state-decoded only, never combinational from in_valid.
  - A word is accepted when in_valid && in_ready.
  - Acceptance in cycle N causes, in cycle N+1:
    - wr_en=1 and wr_addr = pointer;
    - wr_data = word;
    - checksum ^= word, words_written += 1.
    - Write latency is exactly 1 cycle; wr_en is 0 in every other cycle.
  - The pointer increments modulo DEPTH after each acceptance (7 -> 0 wrap).
  - When the accepted word is the last one (remaining count hits 0), next state is DONE.
  - The in_valid=0 stall is unlimited; state and pointer hold.
- DONE:
  - Lasts exactly one cycle, coincident with the final wr_en.
  - done=1, busy=1, in_ready=0.
  - Next state IDLE.
- start outside IDLE is ignored and has no side effects.
- abort:
  - In LOAD, abort has priority over a same-cycle acceptance: that word is discarded and no wr_en follows.
  - Next state IDLE; error=1.
  - A wr_en already scheduled from the previous cycle's acceptance still completes.
  - abort in IDLE or DONE is ignored.
- A word_count of DEPTH starting at a nonzero base writes every word once, wrapping through address 0.

Decomposition:
- Package instr_mem_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH and DEPTH constants;
  - the NOP constant 32'h00000000;
  - the loader_state_t enum (IDLE, LOAD, DONE).
- One natural sub-module, loader_addr_counter: loadable modulo-DEPTH pointer plus remaining-count down-counter, with a last flag.

Test Plan:
- Basic load:
  - Stimulus: start with base_addr=0, word_count=3; stream words 0x11111111, 0x22222222, 0x33333333 back-to-back.
  - Required: wr_en at addresses 0, 1, 2, each one cycle after acceptance; done pulses with the third write; words_written=3; checksum=0x00000000.
- Wrap-around:
  - Stimulus: start with base_addr=6, word_count=4.
  - Required: writes to addresses 6, 7, 0, 1; checksum equals the XOR of the 4 words; busy drops the cycle after done.
- Illegal counts:
  - Stimulus: start with word_count=0, then with word_count=9.
  - Required: error=1 each time, no wr_en, busy=0; the next legal start clears error.
- Stall and ignored start:
  - Stimulus: in_valid toggles 1,0,0,1 during a word_count=2 session; start pulsed mid-session.
  - Required: exactly 2 writes at the correct addresses; the start has no effect.
- Abort:
  - Stimulus: abort in the same cycle as the 2nd accepted word of a word_count=5 session.
  - Required: one write only; that word is not written; error=1; no done; state returns to IDLE.
- Reset mid-session:
  - Stimulus: reset=0 asynchronously after the 2nd word.
  - Required: all outputs 0 immediately; no wr_en after reset release until a new start.
